pe_req_sequencer: RTL and testbench
===================================

# pe_req_sequencer

Request-capture and grant-sequencing stage that sits directly upstream of the 3-to-2 priority encoder `PE_2`. It edge-detects three asynchronous-to-protocol request lines and latches them as sticky pending bits. It drives the pending vector into `PE_2.inp` and issues one encoded grant at a time with a valid/ack handshake, clearing each request once it is serviced. A grant that goes unacknowledged for `TIMEOUT` cycles is withdrawn and flagged.

## Interface
- `TIMEOUT`, default 8: cycles a grant is held without `ack` before it is withdrawn; legal range 2–255.
- `CNT_W`, default 8: width of the serviced-grant counter.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high; one clock domain only.
- `req`  in  3  request lines; a 0→1 transition posts a request. Bit 2 has the highest priority.
- `ack`  in  1  consumer acknowledges the current grant.
- `pend`  out  3  registered pending vector; connects to `PE_2.inp`.
- `gnt_valid`  out  1  a grant is being presented.
- `gnt_code`  out  2  encoded grant, stable while `gnt_valid` is high.
- `timeout`  out  1  one-cycle pulse when a grant is withdrawn unacknowledged.
- `svc_cnt`  out  `CNT_W`  number of acknowledged grants; wraps modulo 2^`CNT_W`.

## Operation
- Encoding, identical to `PE_2`:
  - `pend[2]` → 3
  - else `pend[1]` → 2
  - else `pend[0]` → 1
  - else 0
  - Code 0 is never granted.
- Edge detect: `req_q` is `req` registered. `rise = req & ~req_q`. Every clock sets `pend |= rise`.
- States:
  - IDLE: if `pend != 0`, latch `gnt_code = enc(pend)`, load the wait counter to 0, go to GRANT. Otherwise stay. `ack` is ignored in IDLE.
  - GRANT: `gnt_valid = 1`.
    - If `ack`: clear `pend[gnt_code-1]`, increment `svc_cnt`, go to IDLE.
    - Else if the counter equals `TIMEOUT-1`: pulse `timeout`, go to IDLE, and leave `pend` unchanged.
    - Else increment the counter.
- `gnt_valid` is a decode of state == GRANT (registered state). `gnt_code` is a register written only on the IDLE→GRANT transition.
- A higher-priority request arriving during GRANT does not change `gnt_code`. It is picked up at the next IDLE.
- Simultaneous `ack` and a `rise` on the bit being cleared: the set wins, so the bit stays pending and a new request is counted.
- `ack` and the timeout condition in the same cycle: `ack` wins, with no `timeout` pulse.
- A `req` held high does not re-post. It must fall and rise again.
- `svc_cnt` wraps from 2^`CNT_W`−1 to 0 with no flag.

## Timing
- Reset values: `pend` = 0, `req_q` = 0, state = IDLE, `gnt_valid` = 0, `gnt_code` = 0, `timeout` = 0, `svc_cnt` = 0, wait counter = 0.
- `req` first sampled high at edge n → `pend` bit visible after edge n.
- With the block idle, `gnt_valid`/`gnt_code` are visible after edge n+1, i.e. 2 cycles from the request to the grant.
- `ack` sampled high at edge m:
  - after edge m, `gnt_valid` = 0, the `pend` bit is cleared, and `svc_cnt` is incremented;
  - the next grant appears no earlier than after edge m+1, giving a minimum of one idle cycle between grants.
- `gnt_valid` is held for at most `TIMEOUT` cycles. `timeout` is high for exactly the one cycle after the withdrawing edge, the same cycle in which `gnt_valid` = 0.
- Reset asserted mid-GRANT:
  - all outputs go to their reset values immediately, without waiting for a clock;
  - the pending grant is lost.
  - Because `req_q` resets to 0, a `req` held high across reset release is captured as a new request at the first clock edge after release.

## Test plan
- Single request: pulse `req` = 3'b001 and return `ack` 1 cycle after `gnt_valid` → `gnt_code` = 1 two cycles after the request, `pend` returns to 0, `svc_cnt` = 1.
- Priority order: raise all three `req` bits in the same cycle and ack each grant → grants in order 3, 2, 1, each separated by one `gnt_valid` = 0 cycle; `pend` steps 111 → 011 → 001 → 000.
- No preemption: `req[0]` is granted (code 1); `req[2]` rises during that GRANT → `gnt_code` stays 1 until ack, then the next grant is 3.
- Timeout: grant code 2, never ack, `TIMEOUT` = 8 → `gnt_valid` is high for exactly 8 cycles, then a single-cycle `timeout` pulse; `pend[1]` is still 1; the grant is reissued after one idle cycle.
- Simultaneous events:
  - `ack` in the last wait cycle → no `timeout` pulse, `svc_cnt` increments;
  - `ack` on code 1 in the same cycle as a new `req[0]` rise → `pend[0]` stays 1 and is granted again.
- Reset mid-GRANT with `req[1]` held high → outputs are 0 during reset; after release, `pend` = 010, followed by a grant with code 2.

Source files
------------

// File: rtl/pe_req_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pe_req_sequencer
//  Brief    : Edge-detects three request lines into sticky pending bits that
//             feed the PE_2 priority encoder. Issues one encoded grant at a
//             time with a valid/ack handshake, and withdraws a grant that is
//             not acknowledged within TIMEOUT cycles.
//  Revision : 1.0  initial release
// ============================================================================
module pe_req_sequencer #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req_i,
  input  logic             ack_i,
  output logic [2:0]       pend_o,
  output logic             gnt_valid_o,
  output logic [1:0]       gnt_code_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] svc_cnt_o
);

  localparam int         WAIT_W  = 8;
  localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         req_q;
  logic [2:0]         pend_q, pend_d;
  logic [1:0]         gnt_code_q, gnt_code_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   svc_q, svc_d;
  logic               timeout_q, timeout_d;
  logic [2:0]         rise;
  logic [2:0]         clr;

  // Same encoding as PE_2: highest set bit wins, code 0 means nothing pending.
  function automatic logic [1:0] enc(input logic [2:0] p);
    if (p[2])      enc = 2'd3;
    else if (p[1]) enc = 2'd2;
    else if (p[0]) enc = 2'd1;
    else           enc = 2'd0;
  endfunction

  assign rise = req_i & ~req_q;

  // Next-state logic; a new rise is OR-ed in after the clear so the set wins.
  always_comb begin
    state_d    = state_q;
    gnt_code_d = gnt_code_q;
    wait_d     = wait_q;
    svc_d      = svc_q;
    timeout_d  = 1'b0;
    clr        = 3'b000;
    case (state_q)
      S_IDLE: begin
        if (pend_q != 3'b000) begin
          state_d    = S_GRANT;
          gnt_code_d = enc(pend_q);
          wait_d     = '0;
        end
      end
      S_GRANT: begin
        // ack takes precedence over a coincident timeout.
        if (ack_i) begin
          clr     = 3'b001 << (gnt_code_q - 2'd1);
          svc_d   = svc_q + 1'b1;
          state_d = S_IDLE;
        end else if (wait_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    pend_d = (pend_q & ~clr) | rise;
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_q      <= 3'b000;
      pend_q     <= 3'b000;
      gnt_code_q <= 2'd0;
      wait_q     <= '0;
      svc_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_i;
      pend_q     <= pend_d;
      gnt_code_q <= gnt_code_d;
      wait_q     <= wait_d;
      svc_q      <= svc_d;
      timeout_q  <= timeout_d;
    end
  end

  assign pend_o      = pend_q;
  assign gnt_valid_o = (state_q == S_GRANT);
  assign gnt_code_o  = gnt_code_q;
  assign timeout_o   = timeout_q;
  assign svc_cnt_o   = svc_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_req_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_req_sequencer
//  Brief    : Self-checking bench for pe_req_sequencer; expected grant codes
//             are queued when requests are driven and popped when a grant
//             appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pe_req_sequencer;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 8;

  logic             clk;
  logic             rst;
  logic [2:0]       req_i;
  logic             ack_i;
  logic [2:0]       pend_o;
  logic             gnt_valid_o;
  logic [1:0]       gnt_code_o;
  logic             timeout_o;
  logic [CNT_W-1:0] svc_cnt_o;

  int               n_total;
  int               n_bad;
  int               last_wait;
  logic [1:0]       exp_q[$];
  logic [CNT_W-1:0] exp_svc;

  pe_req_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .ack_i       (ack_i),
    .pend_o      (pend_o),
    .gnt_valid_o (gnt_valid_o),
    .gnt_code_o  (gnt_code_o),
    .timeout_o   (timeout_o),
    .svc_cnt_o   (svc_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; land just after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Wait for a grant, then pop the scoreboard and compare its code.
  task automatic wait_grant(input int budget);
    int n;
    logic [1:0] e;
    n = 0;
    while (!gnt_valid_o && n < budget) begin
      tick();
      n++;
    end
    last_wait = n;
    if (!gnt_valid_o) begin
      chk("gnt_wait", 32'(gnt_valid_o), 32'd1);
    end else if (exp_q.size() == 0) begin
      chk("gnt_unexpected", 32'(gnt_code_o), 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("gnt_code", 32'(gnt_code_o), 32'(e));
    end
  endtask

  task automatic do_ack;
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    exp_svc = exp_svc + 1'b1;
    chk("ack_valid_low", 32'(gnt_valid_o), 32'd0);
    chk("svc_cnt", 32'(svc_cnt_o), 32'(exp_svc));
  endtask

  // Post a request pulse for one cycle and queue its expected code.
  task automatic post(input logic [2:0] r, input logic [1:0] code);
    req_i = r;
    exp_q.push_back(code);
    tick();
    req_i = 3'b000;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    exp_svc = '0;
    rst     = 1'b0;
    req_i   = 3'b000;
    ack_i   = 1'b0;

    // Reset state (asynchronous assertion)
    #2 rst = 1'b1;
    #1;
    chk("rst_pend", 32'(pend_o), 32'd0);
    chk("rst_valid", 32'(gnt_valid_o), 32'd0);
    chk("rst_code", 32'(gnt_code_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_svc", 32'(svc_cnt_o), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single request: grant two cycles after the request
    post(3'b001, 2'd1);
    chk("t1_pend", 32'(pend_o), 32'd1);
    chk("t1_valid_early", 32'(gnt_valid_o), 32'd0);
    tick();
    chk("t1_valid", 32'(gnt_valid_o), 32'd1);
    wait_grant(0);
    tick();
    do_ack();
    chk("t1_pend_clr", 32'(pend_o), 32'd0);

    // Priority order 3, 2, 1 with one idle cycle between grants
    tick();
    post(3'b111, 2'd3);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd1);
    chk("t2_pend111", 32'(pend_o), 32'd7);
    wait_grant(4);
    do_ack();
    chk("t2_pend011", 32'(pend_o), 32'd3);
    wait_grant(4);
    chk("t2_gap", 32'(last_wait), 32'd1);
    do_ack();
    chk("t2_pend001", 32'(pend_o), 32'd1);
    wait_grant(4);
    chk("t2_gap", 32'(last_wait), 32'd1);
    do_ack();
    chk("t2_pend000", 32'(pend_o), 32'd0);

    // No preemption by a higher-priority request
    tick();
    post(3'b001, 2'd1);
    wait_grant(4);
    req_i = 3'b100;
    exp_q.push_back(2'd3);
    tick();
    req_i = 3'b000;
    chk("t3_code_hold", 32'(gnt_code_o), 32'd1);
    chk("t3_pend", 32'(pend_o), 32'd5);
    tick();
    chk("t3_code_hold2", 32'(gnt_code_o), 32'd1);
    do_ack();
    wait_grant(4);
    do_ack();

    // Timeout: valid held exactly TIMEOUT cycles, then one-cycle pulse
    tick();
    post(3'b010, 2'd2);
    wait_grant(4);
    for (int i = 1; i < TIMEOUT; i++) begin
      tick();
      chk("t4_valid_hold", 32'(gnt_valid_o), 32'd1);
      chk("t4_no_timeout", 32'(timeout_o), 32'd0);
    end
    tick();
    chk("t4_valid_drop", 32'(gnt_valid_o), 32'd0);
    chk("t4_timeout", 32'(timeout_o), 32'd1);
    chk("t4_pend_kept", 32'(pend_o), 32'd2);
    exp_q.push_back(2'd2);
    tick();
    chk("t4_timeout_end", 32'(timeout_o), 32'd0);
    chk("t4_reissue", 32'(gnt_valid_o), 32'd1);
    wait_grant(0);
    do_ack();

    // ack in the last wait cycle wins over timeout
    tick();
    post(3'b001, 2'd1);
    wait_grant(4);
    for (int i = 1; i < TIMEOUT; i++) tick();
    do_ack();
    chk("t5_no_timeout", 32'(timeout_o), 32'd0);

    // ack coinciding with a new rise on the same bit: set wins
    tick();
    post(3'b001, 2'd1);
    wait_grant(4);
    ack_i = 1'b1;
    req_i = 3'b001;
    tick();
    ack_i = 1'b0;
    req_i = 3'b000;
    exp_svc = exp_svc + 1'b1;
    chk("t5_svc", 32'(svc_cnt_o), 32'(exp_svc));
    chk("t5_pend_stay", 32'(pend_o), 32'd1);
    exp_q.push_back(2'd1);
    wait_grant(4);
    do_ack();

    // Reset mid-grant with req[1] held high across release
    tick();
    req_i = 3'b010;
    exp_q.push_back(2'd2);
    tick();
    wait_grant(4);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(gnt_valid_o), 32'd0);
    chk("t6_rst_code", 32'(gnt_code_o), 32'd0);
    chk("t6_rst_pend", 32'(pend_o), 32'd0);
    chk("t6_rst_svc", 32'(svc_cnt_o), 32'd0);
    exp_svc = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("t6_pend_recap", 32'(pend_o), 32'd2);
    exp_q.push_back(2'd2);
    wait_grant(4);
    req_i = 3'b000;
    do_ack();

    // Service counter wraps modulo 2^CNT_W
    for (int i = 0; i < (1 << CNT_W); i++) begin
      tick();
      post(3'b001, 2'd1);
      wait_grant(4);
      do_ack();
    end
    chk("t7_wrap", 32'(svc_cnt_o), 32'd1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
